// File: rtl/cbus_axi_pkg.sv
// Shared types and AXI3 encodings for the CBus-to-AXI bridge.
package cbus_axi_pkg;

   // Bridge sequencing: one transaction in flight, DONE is the turnaround cycle.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW   = 3'd3,
      ST_W    = 3'd4,
      ST_B    = 3'd5,
      ST_DONE = 3'd6
   } cbus_axi_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   localparam logic [2:0] MSIZE1 = 3'b000;
   localparam logic [2:0] MSIZE2 = 3'b001;
   localparam logic [2:0] MSIZE4 = 3'b010;
   localparam logic [2:0] MSIZE8 = 3'b011;

   // SLVERR (10) and DECERR (11) both have bit 1 set; OKAY/EXOKAY do not.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/cbus_axi_beat_ctr.sv
// Write-beat counter: cleared at the AW handshake, stepped on each
// non-final W handshake, and compared against the latched burst length.
module cbus_axi_beat_ctr #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [3:0]       len_i,
   output logic             is_last_o,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       cnt_ext;

   // Next count: clear has priority; no wrap because len never exceeds MAX_LEN-1.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_ext   = 4'(cnt_q);
   assign is_last_o = (cnt_ext == len_i);
   assign cnt_o     = cnt_q;

endmodule

// File: rtl/cbus_axi_bridge.sv
// CBus request/response to AXI3 master bridge. One transaction at a time,
// multi-beat reads and writes, per-beat error flags, and a one-cycle DONE
// turnaround so a lingering creq_valid cannot re-launch the same request.
module cbus_axi_bridge
   import cbus_axi_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int AXI_ID     = 0,
   parameter int MAX_LEN    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   // CBus request
   input  logic                    creq_valid,
   input  logic                    creq_is_write,
   input  logic [2:0]              creq_size,
   input  logic [ADDR_WIDTH-1:0]   creq_addr,
   input  logic [3:0]              creq_len,
   input  logic [1:0]              creq_burst,
   input  logic [DATA_WIDTH/8-1:0] creq_strobe,
   input  logic [DATA_WIDTH-1:0]   creq_data,
   // CBus response
   output logic                    cresp_ready,
   output logic                    cresp_last,
   output logic [DATA_WIDTH-1:0]   cresp_data,
   output logic                    cresp_err,
   // AXI read address
   output logic [ID_WIDTH-1:0]     arid,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [3:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   output logic [1:0]              arlock,
   output logic [3:0]              arcache,
   output logic [2:0]              arprot,
   output logic                    arvalid,
   input  logic                    arready,
   // AXI read data
   input  logic [ID_WIDTH-1:0]     rid,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready,
   // AXI write address
   output logic [ID_WIDTH-1:0]     awid,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [3:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic [1:0]              awlock,
   output logic [3:0]              awcache,
   output logic [2:0]              awprot,
   output logic                    awvalid,
   input  logic                    awready,
   // AXI write data
   output logic [ID_WIDTH-1:0]     wid,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   // AXI write response
   input  logic [ID_WIDTH-1:0]     bid,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready
);

   localparam int         CNT_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [3:0] LEN_LIMIT = 4'(MAX_LEN - 1);

   cbus_axi_state_t       state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            len_q, len_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            burst_q, burst_d;

   logic                  ctr_clr, ctr_inc, ctr_is_last;
   logic [CNT_W-1:0]      ctr_cnt;

   // The bridge issues a single fixed ID and never checks returned IDs.
   logic                  unused_ids;
   assign unused_ids = ^{rid, bid, ctr_cnt};

   cbus_axi_beat_ctr #(
      .CNT_W(CNT_W)
   ) u_beat_ctr (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (ctr_clr),
      .inc_i     (ctr_inc),
      .len_i     (len_q),
      .is_last_o (ctr_is_last),
      .cnt_o     (ctr_cnt)
   );

   // State and A-channel field registers; fields stay frozen while a valid is up.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
      end
   end

   // Next state, handshake outputs and CBus responses.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      size_d      = size_q;
      burst_d     = burst_q;
      ctr_clr     = 1'b0;
      ctr_inc     = 1'b0;
      arvalid     = 1'b0;
      rready      = 1'b0;
      awvalid     = 1'b0;
      wvalid      = 1'b0;
      wlast       = 1'b0;
      bready      = 1'b0;
      cresp_ready = 1'b0;
      cresp_last  = 1'b0;
      cresp_err   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (creq_valid) begin
               addr_d  = creq_addr;
               len_d   = creq_len;
               size_d  = creq_size;
               burst_d = creq_burst;
               state_d = creq_is_write ? ST_AW : ST_AR;
            end
         end
         ST_AR: begin
            arvalid = 1'b1;
            if (arready) state_d = ST_R;
         end
         ST_R: begin
            rready      = 1'b1;
            cresp_ready = rvalid;
            cresp_last  = rvalid & rlast;
            cresp_err   = rvalid & resp_is_err(rresp);
            if (rvalid && rlast) state_d = ST_DONE;
         end
         ST_AW: begin
            awvalid = 1'b1;
            if (awready) begin
               ctr_clr = 1'b1;
               state_d = ST_W;
            end
         end
         ST_W: begin
            // The final beat is acknowledged through B, not here.
            wvalid = 1'b1;
            wlast  = ctr_is_last;
            if (wready) begin
               if (ctr_is_last) begin
                  state_d = ST_B;
               end else begin
                  cresp_ready = 1'b1;
                  ctr_inc     = 1'b1;
               end
            end
         end
         ST_B: begin
            bready = 1'b1;
            if (bvalid) begin
               cresp_ready = 1'b1;
               cresp_last  = 1'b1;
               cresp_err   = resp_is_err(bresp);
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign cresp_data = (state_q == ST_R) ? rdata : '0;

   assign arid    = ID_WIDTH'(AXI_ID);
   assign araddr  = addr_q;
   assign arlen   = len_q;
   assign arsize  = size_q;
   assign arburst = burst_q;
   assign arlock  = '0;
   assign arcache = '0;
   assign arprot  = '0;

   assign awid    = ID_WIDTH'(AXI_ID);
   assign awaddr  = addr_q;
   assign awlen   = len_q;
   assign awsize  = size_q;
   assign awburst = burst_q;
   assign awlock  = '0;
   assign awcache = '0;
   assign awprot  = '0;

   assign wid     = ID_WIDTH'(AXI_ID);
   assign wdata   = creq_data;
   assign wstrb   = creq_strobe;

   a_len_in_range: assert property (@(posedge clk) disable iff (reset)
      (state_q == ST_IDLE && creq_valid) |-> (creq_len <= LEN_LIMIT));

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Bench for cbus_axi_bridge: directed vector table, hand sequences for
// turnaround and mid-burst reset, then randomized transactions, all checked
// against transaction-level expectations.
`timescale 1ns/1ps
module tb_cbus_axi_bridge;
   import cbus_axi_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int IW = 4;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          creq_valid, creq_is_write;
   logic [2:0]    creq_size;
   logic [AW-1:0] creq_addr;
   logic [3:0]    creq_len;
   logic [1:0]    creq_burst;
   logic [SW-1:0] creq_strobe;
   logic [DW-1:0] creq_data;
   logic          cresp_ready, cresp_last, cresp_err;
   logic [DW-1:0] cresp_data;
   logic [IW-1:0] arid, awid, wid, rid, bid;
   logic [AW-1:0] araddr, awaddr;
   logic [3:0]    arlen, awlen, arcache, awcache;
   logic [2:0]    arsize, awsize, arprot, awprot;
   logic [1:0]    arburst, awburst, arlock, awlock, rresp, bresp;
   logic          arvalid, arready, rlast, rvalid, rready;
   logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [DW-1:0] rdata, wdata;
   logic [SW-1:0] wstrb;

   always #5 clk = ~clk;

   cbus_axi_bridge dut (
      .clk(clk), .reset(reset),
      .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
      .creq_addr(creq_addr), .creq_len(creq_len), .creq_burst(creq_burst),
      .creq_strobe(creq_strobe), .creq_data(creq_data),
      .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data),
      .cresp_err(cresp_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
      .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
      .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] dat [16];
   logic [SW-1:0] stb [16];

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [15:0] err;    // read: per-beat error; write: bit 0 = bresp error
      int          mode;   // 0 no stalls, 1 stall mask, 2 toggle, 3 random
      logic [15:0] stall;
      int          kind;   // 0 data=index, 1 data=deadbeef^index, 2 random
      int          exp_pulses;
      bit          exp_err;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s at %0t: actual=no handshake required=handshake within bound", name, $time);
   endtask

   task automatic slave_idle();
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00; rid = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
   endtask

   task automatic fill(input int kind);
      for (int i = 0; i < 16; i++) begin
         case (kind)
            0:       begin dat[i] = DW'(i);              stb[i] = '1; end
            1:       begin dat[i] = 32'hdeadbeef ^ DW'(i); stb[i] = '1; end
            default: begin dat[i] = DW'($urandom);       stb[i] = SW'($urandom); end
         endcase
      end
   endtask

   // Runs one CBus transaction while playing the AXI slave; checks every cycle.
   task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [15:0] err, input int mode, input logic [15:0] stall,
                          input bit hold, input int abort_beat,
                          output int pulses, output bit last_err);
      int b, cyc, ilen;
      bit done, stalled, rv, rdy;
      pulses = 0; last_err = 1'b0; ilen = int'(len);

      @(posedge clk); #1;
      slave_idle();
      creq_valid = 1'b1; creq_is_write = wr; creq_addr = addr; creq_len = len;
      creq_size = size; creq_burst = burst; creq_data = '0; creq_strobe = '0;
      @(negedge clk);
      chk("idle_no_avalid", {arvalid, awvalid}, 0);

      // address phase: valid must be up from the first cycle after sampling
      done = 1'b0;
      for (cyc = 0; cyc < 64 && !done; cyc++) begin
         @(posedge clk); #1;
         slave_idle();
         rdy = (mode == 3) ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (wr) awready = rdy; else arready = rdy;
         @(negedge clk);
         if (wr) begin
            chk("awvalid", awvalid, 1); chk("awaddr", awaddr, addr); chk("awlen", awlen, len);
            chk("awsize", awsize, size); chk("awburst", awburst, burst); chk("awid", awid, 0);
            chk("w_before_aw", wvalid, 0); chk("ar_on_write", arvalid, 0);
         end else begin
            chk("arvalid", arvalid, 1); chk("araddr", araddr, addr); chk("arlen", arlen, len);
            chk("arsize", arsize, size); chk("arburst", arburst, burst); chk("arid", arid, 0);
            chk("r_before_ar", rready, 0); chk("aw_on_read", awvalid, 0);
         end
         chk("a_cresp_quiet", {cresp_ready, cresp_last}, 0);
         chk("axi_const", {arlock, arcache, arprot, awlock, awcache, awprot}, 0);
         if (rdy) done = 1'b1;
      end
      if (!done) begin timeout_fail("a_phase"); return; end

      b = 0; done = 1'b0; stalled = 1'b0;
      if (!wr) begin
         for (cyc = 0; cyc < 200 && !done; cyc++) begin
            @(posedge clk); #1;
            slave_idle();
            case (mode)
               0: rv = 1'b1;
               1: if (stall[b] && !stalled) begin rv = 1'b0; stalled = 1'b1; end else rv = 1'b1;
               2: rv = cyc[0];
               default: rv = ($urandom_range(0, 2) != 0);
            endcase
            rvalid = rv;
            rdata  = rv ? dat[b] : DW'($urandom);
            rlast  = rv ? (b == ilen) : 1'b1;
            rresp  = rv ? (err[b] ? {1'b1, b[0]} : 2'b00) : 2'b10;
            @(negedge clk);
            chk("rready", rready, 1);
            chk("r_cresp_ready", cresp_ready, rv);
            chk("r_cresp_last", cresp_last, rv && (b == ilen));
            chk("r_cresp_err", cresp_err, rv && err[b]);
            if (rv) chk("r_cresp_data", cresp_data, dat[b]);
            chk("r_no_arvalid", arvalid, 0);
            if (cresp_ready) pulses++;
            if (cresp_last) last_err = cresp_err;
            if (rv) begin
               if (b == ilen) done = 1'b1;
               else begin b++; stalled = 1'b0; end
            end
         end
         if (!done) begin timeout_fail("r_phase"); return; end
      end else begin
         for (cyc = 0; cyc < 200 && !done; cyc++) begin
            @(posedge clk); #1;
            slave_idle();
            if (abort_beat >= 0 && b == abort_beat) begin
               reset = 1'b1; creq_valid = 1'b0;
               @(posedge clk); #1;
               reset = 1'b0;
               @(negedge clk);
               chk("rst_outputs", {arvalid, awvalid, wvalid, wlast, rready, bready,
                                   cresp_ready, cresp_last, cresp_err}, 0);
               chk("rst_addr", {araddr, awaddr}, 0);
               chk("rst_cresp_data", cresp_data, 0);
               chk("rst_state", dut.state_q, ST_IDLE);
               return;
            end
            creq_data = dat[b]; creq_strobe = stb[b];
            case (mode)
               0: rdy = 1'b1;
               1: if (stall[b] && !stalled) begin rdy = 1'b0; stalled = 1'b1; end else rdy = 1'b1;
               2: rdy = cyc[0];
               default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            wready = rdy;
            @(negedge clk);
            chk("wvalid", wvalid, 1); chk("wdata", wdata, dat[b]); chk("wstrb", wstrb, stb[b]);
            chk("wlast", wlast, b == ilen); chk("wid", wid, 0);
            chk("w_cresp_ready", cresp_ready, rdy && (b != ilen));
            chk("w_cresp_last", cresp_last, 0); chk("w_bready", bready, 0);
            if (cresp_ready) pulses++;
            if (rdy) begin
               if (b == ilen) done = 1'b1;
               else begin b++; stalled = 1'b0; end
            end
         end
         if (!done) begin timeout_fail("w_phase"); return; end

         done = 1'b0;
         for (cyc = 0; cyc < 64 && !done; cyc++) begin
            @(posedge clk); #1;
            slave_idle();
            rv = (mode == 3) ? ($urandom_range(0, 1) == 1) : ((mode == 2) ? cyc[0] : 1'b1);
            bvalid = rv;
            bresp  = rv ? (err[0] ? 2'b10 : 2'b00) : 2'b10;
            @(negedge clk);
            chk("bready", bready, 1); chk("b_wvalid", wvalid, 0);
            chk("b_cresp_ready", cresp_ready, rv); chk("b_cresp_last", cresp_last, rv);
            chk("b_cresp_err", cresp_err, rv && err[0]);
            if (cresp_ready) pulses++;
            if (cresp_last) last_err = cresp_err;
            if (rv) done = 1'b1;
         end
         if (!done) begin timeout_fail("b_phase"); return; end
      end

      // turnaround cycle: slave inputs deliberately noisy, responses must stay quiet
      @(posedge clk); #1;
      slave_idle();
      creq_valid = hold;
      rvalid = 1'b1; rlast = 1'b1; rresp = 2'b10; bvalid = 1'b1; bresp = 2'b10;
      @(negedge clk);
      chk("done_quiet", {cresp_ready, cresp_last, cresp_err, arvalid, awvalid,
                         rready, bready, wvalid}, 0);
      chk("done_cresp_data", cresp_data, 0);
      if (hold) begin
         @(posedge clk); #1;
         slave_idle();
         @(negedge clk);
         chk("idle_no_reissue", {arvalid, awvalid}, 0);
         @(posedge clk); #1;
         @(negedge clk);
         chk("reissue_after_idle", wr ? awvalid : arvalid, 1);
         @(posedge clk); #1;
         reset = 1'b1; creq_valid = 1'b0;
         @(posedge clk); #1;
         reset = 1'b0;
      end
   endtask

   initial begin
      int p;
      bit e;
      bit          rwr;
      logic [3:0]  rlen;
      logic [15:0] rerr;
      logic [31:0] raddr;

      vecs[0] = '{1'b0, 32'h1fc0_0000, 4'd0,  16'h0000, 0, 16'h0000, 1, 1,  1'b0};
      vecs[1] = '{1'b0, 32'h0000_1000, 4'd3,  16'h0000, 1, 16'h000a, 0, 4,  1'b0};
      vecs[2] = '{1'b1, 32'h0000_2000, 4'd7,  16'h0000, 2, 16'h0000, 0, 8,  1'b0};
      vecs[3] = '{1'b1, 32'h0000_3000, 4'd0,  16'h0001, 0, 16'h0000, 0, 1,  1'b1};
      vecs[4] = '{1'b0, 32'h0000_4000, 4'd2,  16'h0004, 0, 16'h0000, 2, 3,  1'b1};
      vecs[5] = '{1'b1, 32'h0000_5000, 4'd15, 16'h0000, 1, 16'h8421, 2, 16, 1'b0};
      vecs[6] = '{1'b0, 32'h0000_7000, 4'd15, 16'h0001, 2, 16'h0000, 2, 16, 1'b0};

      reset = 1'b1;
      slave_idle();
      creq_valid = 1'b0; creq_is_write = 1'b0; creq_size = '0; creq_addr = '0;
      creq_len = '0; creq_burst = '0; creq_strobe = '0; creq_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {arvalid, awvalid, wvalid, wlast, rready, bready,
                            cresp_ready, cresp_last, cresp_err}, 0);
      chk("reset_addr", {araddr, awaddr}, 0);
      chk("reset_len", {arlen, awlen}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_idle", {arvalid, awvalid, cresp_ready}, 0);

      for (int i = 0; i < 7; i++) begin
         fill(vecs[i].kind);
         run_txn(vecs[i].wr, vecs[i].addr, vecs[i].len, MSIZE4, AXI_BURST_INCR,
                 vecs[i].err, vecs[i].mode, vecs[i].stall, 1'b0, -1, p, e);
         chk($sformatf("vec%0d_pulses", i), p, vecs[i].exp_pulses);
         chk($sformatf("vec%0d_last_err", i), e, vecs[i].exp_err);
      end

      // creq_valid held through DONE on a read and on a write
      fill(0);
      run_txn(1'b0, 32'h0000_8000, 4'd1, MSIZE4, AXI_BURST_INCR, 16'h0, 0, 16'h0, 1'b1, -1, p, e);
      chk("hold_read_pulses", p, 2);
      run_txn(1'b1, 32'h0000_9000, 4'd1, MSIZE4, AXI_BURST_INCR, 16'h0, 0, 16'h0, 1'b1, -1, p, e);
      chk("hold_write_pulses", p, 2);

      // reset in the middle of a write burst, then a clean read
      fill(0);
      run_txn(1'b1, 32'h0000_a000, 4'd7, MSIZE4, AXI_BURST_INCR, 16'h0, 0, 16'h0, 1'b0, 2, p, e);
      chk("abort_pulses", p, 2);
      fill(1);
      run_txn(1'b0, 32'h1fc0_0000, 4'd0, MSIZE4, AXI_BURST_INCR, 16'h0, 0, 16'h0, 1'b0, -1, p, e);
      chk("after_reset_pulses", p, 1);

      // randomized transactions: every beat answered once, last carries the final error
      for (int i = 0; i < 40; i++) begin
         rwr   = 1'($urandom_range(0, 1));
         rlen  = 4'($urandom_range(0, 15));
         rerr  = 16'($urandom);
         raddr = $urandom & 32'hffff_fffc;
         fill(2);
         run_txn(rwr, raddr, rlen, 3'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                 rerr, 3, 16'h0, 1'b0, -1, p, e);
         chk("rand_pulses", p, int'(rlen) + 1);
         chk("rand_last_err", e, rwr ? rerr[0] : rerr[rlen]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
